sfence_flush_ctrl: RTL and testbench
====================================

Name: sfence_flush_ctrl

Overview:
Sequences SFENCE.VMA execution for the execute stage, between the CSR/FLU issue path and the load/store unit TLBs. The block captures rs1 (vaddr) and rs2 (ASID) when the sfence issues and waits for it to commit. It then stalls stores and waits for the store path to drain. Finally it drives a one-cycle TLB flush with stable operands and reports completion.

Parameters:
VLEN, 39, virtual address width of vaddr operand
ASID_WIDTH, 1, ASID operand width
DRAIN_TIMEOUT, 64, max cycles in DRAIN before forced flush (optional feature only; >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  pipeline flush (squashes uncommitted sfence)
sfence_valid_i  in  1  SFENCE_VMA issued to FLU this cycle
sfence_ready_o  out  1  controller can accept an sfence (state IDLE)
rs1_i  in  VLEN  forwarded rs1 value
rs2_i  in  ASID_WIDTH  forwarded rs2 value (low bits)
rs1_is_x0_i  in  1  rs1 field is x0 -> flush all vaddr
rs2_is_x0_i  in  1  rs2 field is x0 -> flush all ASIDs
commit_i  in  1  sfence at head of scoreboard commits
no_st_pending_i  in  1  store buffer/commit queue empty
stall_st_o  out  1  block further store commits
flush_tlb_o  out  1  one-cycle TLB flush strobe
vaddr_o  out  VLEN  vaddr to flush (0 if all)
asid_o  out  ASID_WIDTH  ASID to flush (0 if all)
all_vaddr_o  out  1  flush ignores vaddr
all_asid_o  out  1  flush ignores ASID
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
timeout_o  out  1  sticky: drain timed out (optional feature; else tied 0)

Behaviour:
- Reset (rst_ni=0 at posedge): state IDLE; all outputs 0 except sfence_ready_o=1; operand regs and counter cleared.
- States: IDLE, WAIT_COMMIT, DRAIN, FLUSH, DONE.
- IDLE: sfence_valid_i=1 and flush_i=0 -> latch operands and x0 flags -> WAIT_COMMIT. With flush_i=1 in the same cycle: no capture, stay IDLE. commit_i in IDLE ignored.
- Operand latch: when rs1_is_x0_i, vaddr reg=0 and all_vaddr=1. When rs2_is_x0_i, asid reg=0 and all_asid=1. Operands held unchanged from capture until return to IDLE.
- WAIT_COMMIT: flush_i=1 -> IDLE, no TLB flush. Otherwise commit_i=1 -> DRAIN. flush_i has priority over a same-cycle commit_i.
- DRAIN: stall_st_o=1. no_st_pending_i=1 -> FLUSH; this also applies in the first DRAIN cycle, so min DRAIN residency is 1 cycle. flush_i ignored (sfence committed).
- FLUSH: flush_tlb_o=1 for exactly this cycle; stall_st_o=1; -> DONE.
- DONE: done_o=1 for exactly this cycle; stall_st_o=0; -> IDLE.
- vaddr_o/asid_o/all_*_o are registered. They are valid from WAIT_COMMIT through DONE and 0 in IDLE.
- sfence_ready_o=0 in every non-IDLE state. sfence_valid_i while not ready is a protocol violation: ignored, captured state unchanged.
- Minimum latency: commit_i cycle N -> flush_tlb_o at N+2 and done_o at N+3, when no_st_pending_i=1.
- Reset mid-operation: any state -> IDLE at next posedge with rst_ni=0; no flush_tlb_o is emitted.

Optional Feature:
SFENCE_DRAIN_TIMEOUT_EN
- Defined: an 8+ bit counter (width $clog2(DRAIN_TIMEOUT+1)) clears on DRAIN entry and increments each DRAIN cycle. When the count reaches DRAIN_TIMEOUT-1 with no_st_pending_i=0, go to FLUSH anyway and set timeout_o. timeout_o is cleared only by reset.
- Undefined: no counter; DRAIN waits indefinitely for no_st_pending_i; timeout_o tied 0; DRAIN_TIMEOUT unused.

Test Plan:
- Basic flush: sfence_valid_i with rs1=0x40_0000_1000, rs2=1, x0 flags=0; commit_i 3 cycles later; no_st_pending_i=1 -> flush_tlb_o 2 cycles after commit with vaddr_o=0x40_0000_1000, asid_o=1; done_o next cycle; sfence_ready_o back to 1.
- Global flush: rs1_is_x0_i=1 and rs2_is_x0_i=1 with rs1=0xDEAD -> all_vaddr_o=1, all_asid_o=1, vaddr_o=0, asid_o=0 at the flush strobe.
- Squash: capture, then flush_i and commit_i in the same cycle in WAIT_COMMIT -> IDLE next cycle, no flush_tlb_o over 20 cycles, busy_o=0.
- Drain wait: no_st_pending_i=0 for 10 cycles after commit -> stall_st_o=1 for those cycles; flush_tlb_o 1 cycle after no_st_pending_i rises; flush_i during DRAIN has no effect.
- Timeout (macro defined, DRAIN_TIMEOUT=8): no_st_pending_i held 0 -> flush_tlb_o after 8 DRAIN cycles and timeout_o=1 sticky. Macro undefined: no flush after 100 cycles.
- Reset mid-DRAIN: rst_ni=0 for one cycle -> all outputs at reset values, no flush_tlb_o; a new sfence is accepted afterwards.

Source files
------------

// File: rtl/sfence_flush_ctrl_if.sv
// Signal bundle between the execute-stage issue path, the sfence controller and the LSU TLBs.
// The slave modport is the controller's view; the master modport is the surrounding pipeline's view.
interface sfence_flush_ctrl_if #(
    parameter int VLEN       = 39,
    parameter int ASID_WIDTH = 1
);
    logic                  flush_i;
    logic                  sfence_valid_i;
    logic                  sfence_ready_o;
    logic [VLEN-1:0]       rs1_i;
    logic [ASID_WIDTH-1:0] rs2_i;
    logic                  rs1_is_x0_i;
    logic                  rs2_is_x0_i;
    logic                  commit_i;
    logic                  no_st_pending_i;
    logic                  stall_st_o;
    logic                  flush_tlb_o;
    logic [VLEN-1:0]       vaddr_o;
    logic [ASID_WIDTH-1:0] asid_o;
    logic                  all_vaddr_o;
    logic                  all_asid_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  timeout_o;

    modport slave (
        input  flush_i, sfence_valid_i, rs1_i, rs2_i, rs1_is_x0_i, rs2_is_x0_i,
               commit_i, no_st_pending_i,
        output sfence_ready_o, stall_st_o, flush_tlb_o, vaddr_o, asid_o,
               all_vaddr_o, all_asid_o, busy_o, done_o, timeout_o
    );

    modport master (
        output flush_i, sfence_valid_i, rs1_i, rs2_i, rs1_is_x0_i, rs2_is_x0_i,
               commit_i, no_st_pending_i,
        input  sfence_ready_o, stall_st_o, flush_tlb_o, vaddr_o, asid_o,
               all_vaddr_o, all_asid_o, busy_o, done_o, timeout_o
    );
endinterface

// File: rtl/sfence_flush_ctrl.sv
// SFENCE.VMA sequencer: capture operands, wait for commit, drain stores, strobe TLB flush.
// Optional drain watchdog enabled by defining SFENCE_DRAIN_TIMEOUT_EN.
module sfence_flush_ctrl #(
    parameter int VLEN          = 39,
    parameter int ASID_WIDTH    = 1,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    sfence_flush_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_COMMIT = 3'd1,
        DRAIN       = 3'd2,
        FLUSH       = 3'd3,
        DONE        = 3'd4
    } state_t;

    if (DRAIN_TIMEOUT < 2) begin : g_bad_timeout
        $error("DRAIN_TIMEOUT must be >= 2");
    end

    state_t                r_state;
    state_t                w_next;
    logic                  w_capture;
    logic                  w_to_hit;
    logic [VLEN-1:0]       r_vaddr;
    logic [ASID_WIDTH-1:0] r_asid;
    logic                  r_all_vaddr;
    logic                  r_all_asid;
    logic                  r_timeout;

`ifdef SFENCE_DRAIN_TIMEOUT_EN
    localparam int CNT_W = ($clog2(DRAIN_TIMEOUT + 1) > 8) ? $clog2(DRAIN_TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_expired;

    assign w_cnt_expired = (r_cnt == CNT_W'(DRAIN_TIMEOUT - 1));

    // Counter is held at zero outside DRAIN, so it is clear on every DRAIN entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= (r_state == DRAIN) ? r_cnt + 1'b1 : '0;
            if (w_to_hit) r_timeout <= 1'b1;
        end
    end
`else
    logic w_cnt_expired;
    assign w_cnt_expired = 1'b0;
    assign r_timeout     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_to_hit  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.sfence_valid_i && !bus.flush_i) begin
                    w_capture = 1'b1;
                    w_next    = WAIT_COMMIT;
                end
            end
            WAIT_COMMIT: begin
                // A squash wins over a same-cycle commit.
                if (bus.flush_i)       w_next = IDLE;
                else if (bus.commit_i) w_next = DRAIN;
            end
            DRAIN: begin
                if (bus.no_st_pending_i) begin
                    w_next = FLUSH;
                end else if (w_cnt_expired) begin
                    w_next   = FLUSH;
                    w_to_hit = 1'b1;
                end
            end
            FLUSH:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands stay frozen from capture until the controller returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vaddr     <= '0;
            r_asid      <= '0;
            r_all_vaddr <= 1'b0;
            r_all_asid  <= 1'b0;
        end else if (w_capture) begin
            r_vaddr     <= bus.rs1_is_x0_i ? '0 : bus.rs1_i;
            r_asid      <= bus.rs2_is_x0_i ? '0 : bus.rs2_i;
            r_all_vaddr <= bus.rs1_is_x0_i;
            r_all_asid  <= bus.rs2_is_x0_i;
        end else if (w_next == IDLE) begin
            r_vaddr     <= '0;
            r_asid      <= '0;
            r_all_vaddr <= 1'b0;
            r_all_asid  <= 1'b0;
        end
    end

    always_comb begin
        bus.sfence_ready_o = (r_state == IDLE);
        bus.busy_o         = (r_state != IDLE);
        bus.stall_st_o     = (r_state == DRAIN) || (r_state == FLUSH);
        bus.flush_tlb_o    = (r_state == FLUSH);
        bus.done_o         = (r_state == DONE);
        bus.vaddr_o        = r_vaddr;
        bus.asid_o         = r_asid;
        bus.all_vaddr_o    = r_all_vaddr;
        bus.all_asid_o     = r_all_asid;
        bus.timeout_o      = r_timeout;
    end
endmodule

// File: tb/tb_sfence_flush_ctrl.sv
// Bench for sfence_flush_ctrl: directed scenarios plus random traffic against a
// timestamp-based reference model of the sfence lifetime.
module tb_sfence_flush_ctrl;
    localparam int VLEN = 39;
    localparam int AW   = 1;
    localparam int DT   = 8;

    logic clk = 1'b0;
    logic rst_ni;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_flush = 0;
    bit   chk_en = 1'b0;

    sfence_flush_ctrl_if #(.VLEN(VLEN), .ASID_WIDTH(AW)) bus ();

    sfence_flush_ctrl #(.VLEN(VLEN), .ASID_WIDTH(AW), .DRAIN_TIMEOUT(DT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: an sfence is described by when it was captured, the first
    // cycle after commit, and the cycle of its flush strobe. Everything else follows.
    int              cyc = 0;
    bit              m_cap = 1'b0;
    int              m_commit_at = -1;
    int              m_flush_at = -1;
    logic [VLEN-1:0] m_vaddr = '0;
    logic [AW-1:0]   m_asid = '0;
    bit              m_allv = 1'b0;
    bit              m_alla = 1'b0;
    bit              m_to = 1'b0;

    function automatic void m_drop();
        m_cap = 1'b0; m_commit_at = -1; m_flush_at = -1;
        m_vaddr = '0; m_asid = '0; m_allv = 1'b0; m_alla = 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_ni) begin
            m_drop();
            m_to = 1'b0;
        end else if (!m_cap) begin
            if (bus.sfence_valid_i && !bus.flush_i) begin
                m_cap   = 1'b1;
                m_allv  = bus.rs1_is_x0_i;
                m_alla  = bus.rs2_is_x0_i;
                m_vaddr = m_allv ? '0 : bus.rs1_i;
                m_asid  = m_alla ? '0 : bus.rs2_i;
            end
        end else if (m_commit_at < 0) begin
            if (bus.flush_i)       m_drop();
            else if (bus.commit_i) m_commit_at = cyc;
        end else if (m_flush_at < 0) begin
            if (bus.no_st_pending_i) m_flush_at = cyc;
`ifdef SFENCE_DRAIN_TIMEOUT_EN
            else if (cyc - m_commit_at == DT) begin
                m_flush_at = cyc;
                m_to       = 1'b1;
            end
`endif
        end else if (cyc == m_flush_at + 2) begin
            m_drop();
        end
    end

    always @(negedge clk) begin
        if (bus.flush_tlb_o === 1'b1) n_flush++;
        if (chk_en) begin
            bit e_flush, e_done, e_stall;
            e_flush = m_cap && (m_flush_at == cyc);
            e_done  = m_cap && (m_flush_at >= 0) && (cyc == m_flush_at + 1);
            e_stall = m_cap && (m_commit_at >= 0) && !e_done;
            chk("ready",     64'(bus.sfence_ready_o), 64'(!m_cap));
            chk("busy",      64'(bus.busy_o),         64'(m_cap));
            chk("stall",     64'(bus.stall_st_o),     64'(e_stall));
            chk("flush_tlb", 64'(bus.flush_tlb_o),    64'(e_flush));
            chk("done",      64'(bus.done_o),         64'(e_done));
            chk("vaddr",     64'(bus.vaddr_o),        64'(m_vaddr));
            chk("asid",      64'(bus.asid_o),         64'(m_asid));
            chk("all_vaddr", 64'(bus.all_vaddr_o),    64'(m_allv));
            chk("all_asid",  64'(bus.all_asid_o),     64'(m_alla));
            chk("timeout",   64'(bus.timeout_o),      64'(m_to));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle_inputs();
        bus.flush_i = 1'b0; bus.sfence_valid_i = 1'b0; bus.rs1_i = '0; bus.rs2_i = '0;
        bus.rs1_is_x0_i = 1'b0; bus.rs2_is_x0_i = 1'b0; bus.commit_i = 1'b0;
        bus.no_st_pending_i = 1'b1;
    endtask

    task automatic issue(input logic [VLEN-1:0] a, input logic [AW-1:0] s, input bit x1, input bit x2);
        bus.sfence_valid_i = 1'b1; bus.rs1_i = a; bus.rs2_i = s;
        bus.rs1_is_x0_i = x1; bus.rs2_is_x0_i = x2;
        step();
        bus.sfence_valid_i = 1'b0; bus.rs1_is_x0_i = 1'b0; bus.rs2_is_x0_i = 1'b0;
    endtask

    initial begin
        int snap;
        logic [63:0] r64;
        idle_inputs();
        rst_ni = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst_ni = 1'b1;
        chk("rst_ready", 64'(bus.sfence_ready_o), 64'd1);
        chk("rst_busy",  64'(bus.busy_o),         64'd0);
        chk("rst_vaddr", 64'(bus.vaddr_o),        64'd0);

        // Basic flush: commit three cycles after issue, strobe two cycles after commit.
        issue(39'h40_0000_1000, 1'b1, 1'b0, 1'b0);
        chk("cap_busy", 64'(bus.busy_o), 64'd1);
        chk("cap_vaddr", 64'(bus.vaddr_o), 64'h40_0000_1000);
        step(2);
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
        chk("drain_stall", 64'(bus.stall_st_o), 64'd1);
        step();
        chk("basic_flush", 64'(bus.flush_tlb_o), 64'd1);
        chk("basic_vaddr", 64'(bus.vaddr_o), 64'h40_0000_1000);
        chk("basic_asid",  64'(bus.asid_o), 64'd1);
        step();
        chk("basic_done", 64'(bus.done_o), 64'd1);
        step();
        chk("basic_ready", 64'(bus.sfence_ready_o), 64'd1);

        // Global flush.
        issue(39'hDEAD, 1'b1, 1'b1, 1'b1);
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
        step();
        chk("glob_flush", 64'(bus.flush_tlb_o), 64'd1);
        chk("glob_allv",  64'(bus.all_vaddr_o), 64'd1);
        chk("glob_alla",  64'(bus.all_asid_o), 64'd1);
        chk("glob_vaddr", 64'(bus.vaddr_o), 64'd0);
        step(2);

        // Squash with same-cycle commit.
        issue(39'h1234, 1'b0, 1'b0, 1'b0);
        bus.flush_i = 1'b1; bus.commit_i = 1'b1;
        step();
        bus.flush_i = 1'b0; bus.commit_i = 1'b0;
        chk("squash_busy", 64'(bus.busy_o), 64'd0);
        snap = n_flush;
        step(20);
        chk("squash_noflush", 64'(n_flush - snap), 64'd0);

        // Drain wait with flush_i pulses that must be ignored.
        bus.no_st_pending_i = 1'b0;
        issue(39'h7_0000_0000, 1'b1, 1'b0, 1'b0);
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
`ifdef SFENCE_DRAIN_TIMEOUT_EN
        for (int i = 0; i < DT - 2; i++) begin
`else
        for (int i = 0; i < 10; i++) begin
`endif
            chk("dw_stall", 64'(bus.stall_st_o), 64'd1);
            chk("dw_noflush", 64'(bus.flush_tlb_o), 64'd0);
            bus.flush_i = (i % 3 == 0);
            step();
        end
        bus.flush_i = 1'b0;
        bus.no_st_pending_i = 1'b1;
        step();
        chk("dw_flush", 64'(bus.flush_tlb_o), 64'd1);
        step(2);

        // Stores never drain.
        bus.no_st_pending_i = 1'b0;
        issue(39'h55, 1'b0, 1'b0, 1'b0);
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
        snap = n_flush;
        step(100);
`ifdef SFENCE_DRAIN_TIMEOUT_EN
        chk("to_flushes", 64'(n_flush - snap), 64'd1);
        chk("to_sticky",  64'(bus.timeout_o), 64'd1);
`else
        chk("to_noflush", 64'(n_flush - snap), 64'd0);
        chk("to_stuck",   64'(bus.stall_st_o), 64'd1);
`endif
        bus.no_st_pending_i = 1'b1;
        step(3);

        // Reset mid-DRAIN.
        bus.no_st_pending_i = 1'b0;
        issue(39'h99, 1'b1, 1'b0, 1'b0);
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
        step(2);
        rst_ni = 1'b0;
        snap = n_flush;
        step();
        rst_ni = 1'b1;
        chk("mr_busy",  64'(bus.busy_o), 64'd0);
        chk("mr_stall", 64'(bus.stall_st_o), 64'd0);
        chk("mr_ready", 64'(bus.sfence_ready_o), 64'd1);
        chk("mr_to",    64'(bus.timeout_o), 64'd0);
        step(3);
        chk("mr_noflush", 64'(n_flush - snap), 64'd0);
        bus.no_st_pending_i = 1'b1;
        issue(39'h1000, 1'b0, 1'b0, 1'b0);
        chk("mr_accept", 64'(bus.busy_o), 64'd1);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r64 = {$urandom(), $urandom()};
            bus.sfence_valid_i  = ($urandom_range(99) < 30);
            bus.flush_i         = ($urandom_range(99) < 10);
            bus.commit_i        = ($urandom_range(99) < 30);
            bus.no_st_pending_i = ($urandom_range(99) < 50);
            bus.rs1_is_x0_i     = ($urandom_range(99) < 25);
            bus.rs2_is_x0_i     = ($urandom_range(99) < 25);
            bus.rs1_i           = r64[VLEN-1:0];
            bus.rs2_i           = r64[63 -: AW];
            rst_ni              = ($urandom_range(199) != 0);
            step();
        end
        idle_inputs();
        rst_ni = 1'b1;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
